// File: rtl/fmap_pkg.sv
// Shared types and sizing helpers for the feature-map writer.
package fmap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fmap_state_e;

    localparam int unsigned DEFAULT_ADDR_W = 18;

    function automatic int unsigned calc_output_size(input int unsigned out_w,
                                                     input int unsigned out_h);
        return out_w * out_h;
    endfunction

endpackage

// File: rtl/fmap_bram_3r1w.sv
// One channel buffer: single write port, three registered read-first ports.
// Reads beyond DEPTH return zero.
module fmap_bram_3r1w #(
    parameter int unsigned DATA_WIDTH = 22,
    parameter int unsigned ADDR_W     = 18,
    parameter int unsigned DEPTH      = 49284
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr0,
    input  logic [ADDR_W-1:0]     rd_addr1,
    input  logic [ADDR_W-1:0]     rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data0,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     rd_addr_c [3];
    logic [DATA_WIDTH-1:0] rd_data_d [3];
    logic [DATA_WIDTH-1:0] rd_data_q [3];

    assign rd_addr_c[0] = rd_addr0;
    assign rd_addr_c[1] = rd_addr1;
    assign rd_addr_c[2] = rd_addr2;

    // Array is sampled before this edge's write lands, giving read-first behaviour.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rd_data_d[i] = '0;
            if (32'(rd_addr_c[i]) < DEPTH) begin
                rd_data_d[i] = mem[IDX_W'(rd_addr_c[i])];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                rd_data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                rd_data_q[i] <= rd_data_d[i];
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < DEPTH)) begin
            mem[IDX_W'(wr_addr)] <= wr_data;
        end
    end

    assign rd_data0 = rd_data_q[0];
    assign rd_data1 = rd_data_q[1];
    assign rd_data2 = rd_data_q[2];

endmodule

// File: rtl/fmap_writer.sv
// Feature-map write side: captures a 3-channel result stream row-major into
// per-channel buffers. Define FMAP_RELU_EN to clamp negative inputs to zero.
module fmap_writer
    import fmap_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 22,
    parameter int unsigned OUT_W      = 222,
    parameter int unsigned OUT_H      = 222,
    parameter int unsigned ADDR_W     = DEFAULT_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data0,
    input  logic [DATA_WIDTH-1:0] in_data1,
    input  logic [DATA_WIDTH-1:0] in_data2,
    output logic                  in_ready,
    input  logic [ADDR_W-1:0]     rd_addr0_0,
    input  logic [ADDR_W-1:0]     rd_addr0_1,
    input  logic [ADDR_W-1:0]     rd_addr0_2,
    input  logic [ADDR_W-1:0]     rd_addr1_0,
    input  logic [ADDR_W-1:0]     rd_addr1_1,
    input  logic [ADDR_W-1:0]     rd_addr1_2,
    input  logic [ADDR_W-1:0]     rd_addr2_0,
    input  logic [ADDR_W-1:0]     rd_addr2_1,
    input  logic [ADDR_W-1:0]     rd_addr2_2,
    output logic [DATA_WIDTH-1:0] rd_data0_0,
    output logic [DATA_WIDTH-1:0] rd_data0_1,
    output logic [DATA_WIDTH-1:0] rd_data0_2,
    output logic [DATA_WIDTH-1:0] rd_data1_0,
    output logic [DATA_WIDTH-1:0] rd_data1_1,
    output logic [DATA_WIDTH-1:0] rd_data1_2,
    output logic [DATA_WIDTH-1:0] rd_data2_0,
    output logic [DATA_WIDTH-1:0] rd_data2_1,
    output logic [DATA_WIDTH-1:0] rd_data2_2,
    output logic [ADDR_W-1:0]     wr_count,
    output logic                  done,
    output logic                  overflow
);

    localparam int unsigned OUTPUT_SIZE = calc_output_size(OUT_W, OUT_H);
    localparam int unsigned LAST_ADDR   = OUTPUT_SIZE - 1;
    localparam int unsigned LAST_COL    = OUT_W - 1;

    fmap_state_e           state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [ADDR_W-1:0]     col_q, col_d;
    logic [ADDR_W-1:0]     row_q, row_d;
    logic [ADDR_W-1:0]     wr_count_q, wr_count_d;
    logic                  overflow_q, overflow_d;
    logic                  in_ready_q, in_ready_d;
    logic                  done_q, done_d;
    logic                  wr_en_c;
    logic [DATA_WIDTH-1:0] wr_data0_c, wr_data1_c, wr_data2_c;

`ifdef FMAP_RELU_EN
    function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] v);
        return v[DATA_WIDTH-1] ? '0 : v;
    endfunction
    assign wr_data0_c = relu(in_data0);
    assign wr_data1_c = relu(in_data1);
    assign wr_data2_c = relu(in_data2);
`else
    assign wr_data0_c = in_data0;
    assign wr_data1_c = in_data1;
    assign wr_data2_c = in_data2;
`endif

    // Next-state, counters and sticky overflow; start overrides everything.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        col_d      = col_q;
        row_d      = row_q;
        wr_count_d = wr_count_q;
        overflow_d = overflow_q;
        wr_en_c    = 1'b0;
        if (start) begin
            state_d    = ST_FILL;
            addr_d     = '0;
            col_d      = '0;
            row_d      = '0;
            wr_count_d = '0;
            overflow_d = 1'b0;
        end else begin
            if (in_valid && (state_q != ST_FILL)) begin
                overflow_d = 1'b1;
            end
            case (state_q)
                ST_IDLE: ;
                ST_FILL: begin
                    if (in_valid) begin
                        wr_en_c = 1'b1;
                        addr_d  = addr_q + ADDR_W'(1);
                        if (col_q == ADDR_W'(LAST_COL)) begin
                            col_d = '0;
                            row_d = row_q + ADDR_W'(1);
                        end else begin
                            col_d = col_q + ADDR_W'(1);
                        end
                        if (32'(wr_count_q) < OUTPUT_SIZE) begin
                            wr_count_d = wr_count_q + ADDR_W'(1);
                        end
                        if (addr_q == ADDR_W'(LAST_ADDR)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: ;
                default: state_d = ST_IDLE;
            endcase
        end
        in_ready_d = (state_d == ST_FILL);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            wr_count_q <= '0;
            overflow_q <= 1'b0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            col_q      <= col_d;
            row_q      <= row_d;
            wr_count_q <= wr_count_d;
            overflow_q <= overflow_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
        end
    end

    fmap_bram_3r1w #(.DATA_WIDTH(DATA_WIDTH), .ADDR_W(ADDR_W), .DEPTH(OUTPUT_SIZE)) u_ch0 (
        .clk(clk), .rst(rst), .wr_en(wr_en_c), .wr_addr(addr_q), .wr_data(wr_data0_c),
        .rd_addr0(rd_addr0_0), .rd_addr1(rd_addr0_1), .rd_addr2(rd_addr0_2),
        .rd_data0(rd_data0_0), .rd_data1(rd_data0_1), .rd_data2(rd_data0_2)
    );

    fmap_bram_3r1w #(.DATA_WIDTH(DATA_WIDTH), .ADDR_W(ADDR_W), .DEPTH(OUTPUT_SIZE)) u_ch1 (
        .clk(clk), .rst(rst), .wr_en(wr_en_c), .wr_addr(addr_q), .wr_data(wr_data1_c),
        .rd_addr0(rd_addr1_0), .rd_addr1(rd_addr1_1), .rd_addr2(rd_addr1_2),
        .rd_data0(rd_data1_0), .rd_data1(rd_data1_1), .rd_data2(rd_data1_2)
    );

    fmap_bram_3r1w #(.DATA_WIDTH(DATA_WIDTH), .ADDR_W(ADDR_W), .DEPTH(OUTPUT_SIZE)) u_ch2 (
        .clk(clk), .rst(rst), .wr_en(wr_en_c), .wr_addr(addr_q), .wr_data(wr_data2_c),
        .rd_addr0(rd_addr2_0), .rd_addr1(rd_addr2_1), .rd_addr2(rd_addr2_2),
        .rd_data0(rd_data2_0), .rd_data1(rd_data2_1), .rd_data2(rd_data2_2)
    );

    assign in_ready = in_ready_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_fmap_writer.sv
// Directed bench for fmap_writer on a 4x3 frame.
module tb_fmap_writer;

    localparam int unsigned DW = 22;
    localparam int unsigned AW = 18;

    typedef struct {
        int unsigned port;
        int unsigned addr;
        int unsigned exp;
    } rd_vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data0, in_data1, in_data2;
    logic          in_ready, done, overflow;
    logic [AW-1:0] wr_count;
    logic [AW-1:0] ra [9];
    logic [DW-1:0] rd [9];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fmap_writer #(.DATA_WIDTH(DW), .OUT_W(4), .OUT_H(3), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2),
        .in_ready(in_ready),
        .rd_addr0_0(ra[0]), .rd_addr0_1(ra[1]), .rd_addr0_2(ra[2]),
        .rd_addr1_0(ra[3]), .rd_addr1_1(ra[4]), .rd_addr1_2(ra[5]),
        .rd_addr2_0(ra[6]), .rd_addr2_1(ra[7]), .rd_addr2_2(ra[8]),
        .rd_data0_0(rd[0]), .rd_data0_1(rd[1]), .rd_data0_2(rd[2]),
        .rd_data1_0(rd[3]), .rd_data1_1(rd[4]), .rd_data1_2(rd[5]),
        .rd_data2_0(rd[6]), .rd_data2_1(rd[7]), .rd_data2_2(rd[8]),
        .wr_count(wr_count), .done(done), .overflow(overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic beat(input int d0, input int d1, input int d2);
        in_valid = 1'b1;
        in_data0 = DW'(d0);
        in_data1 = DW'(d1);
        in_data2 = DW'(d2);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic read_chk(input string nm, input int unsigned port,
                            input int unsigned addr, input int unsigned exp);
        ra[port] = AW'(addr);
        tick();
        chk(nm, 32'(rd[port]), exp);
    endtask

    rd_vec_t vecs [8];

    task automatic run_table(input string nm);
        for (int i = 0; i < 8; i++) begin
            read_chk($sformatf("%s_rd%0d", nm, i), vecs[i].port, vecs[i].addr, vecs[i].exp);
        end
    endtask

    initial begin
        vecs[0] = '{port: 1, addr: 5,    exp: 5};
        vecs[1] = '{port: 8, addr: 11,   exp: 211};
        vecs[2] = '{port: 0, addr: 0,    exp: 0};
        vecs[3] = '{port: 4, addr: 7,    exp: 107};
        vecs[4] = '{port: 6, addr: 0,    exp: 200};
        vecs[5] = '{port: 2, addr: 11,   exp: 11};
        vecs[6] = '{port: 3, addr: 12,   exp: 0};
        vecs[7] = '{port: 5, addr: 4095, exp: 0};

        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        in_data0 = '0; in_data1 = '0; in_data2 = '0;
        for (int i = 0; i < 9; i++) ra[i] = '0;
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_wr_count", 32'(wr_count), 0);
        chk("rst_rd_data", 32'(rd[0]), 0);
        rst = 1'b1;

        // Beat in IDLE overflows; start with a beat present clears it and drops the beat.
        beat(999, 999, 999);
        chk("idle_overflow", 32'(overflow), 1);
        in_valid = 1'b1;
        pulse_start();
        in_valid = 1'b0;
        chk("start_overflow_clr", 32'(overflow), 0);
        chk("start_in_ready", 32'(in_ready), 1);
        chk("start_wr_count", 32'(wr_count), 0);

        // Contiguous frame.
        for (int k = 0; k < 12; k++) begin
            in_valid = 1'b1;
            in_data0 = DW'(k); in_data1 = DW'(100 + k); in_data2 = DW'(200 + k);
            tick();
            if (k == 10) chk("contig_done_early", 32'(done), 0);
        end
        in_valid = 1'b0;
        chk("contig_done", 32'(done), 1);
        chk("contig_wr_count", 32'(wr_count), 12);
        chk("contig_in_ready", 32'(in_ready), 0);
        run_table("contig");

        // Extra beat after done.
        beat(77, 0, 0);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_done_hold", 32'(done), 1);
        read_chk("ovf_addr0", 0, 0, 0);
        chk("ovf_wr_count_sat", 32'(wr_count), 12);
        pulse_start();
        chk("restart_overflow", 32'(overflow), 0);
        chk("restart_done", 32'(done), 0);
        chk("restart_in_ready", 32'(in_ready), 1);

        // Gapped frame with identical data.
        for (int k = 0; k < 12; k++) begin
            beat(k, 100 + k, 200 + k);
            chk($sformatf("gap_done_b%0d", k), 32'(done), (k == 11) ? 1 : 0);
            tick();
            chk($sformatf("gap_done_g%0d", k), 32'(done), (k == 11) ? 1 : 0);
        end
        chk("gap_overflow", 32'(overflow), 0);
        run_table("gap");

        // Reset mid-frame, then a fresh frame.
        pulse_start();
        for (int k = 0; k < 6; k++) beat(50 + k, 150 + k, 250 + k);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midrst_in_ready", 32'(in_ready), 0);
        chk("midrst_wr_count", 32'(wr_count), 0);
        chk("midrst_done", 32'(done), 0);
        pulse_start();
        for (int k = 0; k < 12; k++) beat(300 + k, 400 + k, 500 + k);
        chk("frame2_done", 32'(done), 1);
        read_chk("frame2_addr0", 0, 0, 300);
        read_chk("frame2_c1_addr3", 3, 3, 403);

        // Read-first collision on channel 1 address 3, and signed store at address 2.
        pulse_start();
        beat(600, 700, 800);
        beat(601, 701, 801);
        beat(-5, 702, 802);
        ra[3] = AW'(3);
        beat(603, 777, 803);
        chk("rf_old", 32'(rd[3]), 403);
        tick();
        chk("rf_new", 32'(rd[3]), 777);
        read_chk("rf_oob", 3, 12, 0);
`ifdef FMAP_RELU_EN
        read_chk("neg_store", 0, 2, 0);
`else
        read_chk("neg_store", 0, 2, 32'h3FFFFB);
`endif
        for (int k = 4; k < 12; k++) beat(600 + k, 700 + k, 800 + k);
        chk("frame3_done", 32'(done), 1);
        chk("frame3_wr_count", 32'(wr_count), 12);
        read_chk("frame3_addr11", 8, 11, 811);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fmap_writer.md
Name: fmap_writer

Overview:
- Write side of the feature-map buffer between conv layers.
- Accepts the per-filter result stream of a conv layer (3 channels per beat) and stores it row-major at address row*OUT_W+col, one buffer per channel.
- Exposes 9 registered read ports (3 channels x 3 window rows) for the downstream window streamer.
- Asserts done once a full OUT_W x OUT_H frame is stored.

Parameters:
- DATA_WIDTH, 22, width of one stored result word (signed two's complement).
- OUT_W, 222, feature-map width in words.
- OUT_H, 222, feature-map height in rows.
- OUTPUT_SIZE, OUT_W*OUT_H, words per channel buffer.
- ADDR_W, 18, address width; must satisfy 2^ADDR_W >= OUTPUT_SIZE.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle pulse; clears counters, done and overflow, and begins frame capture.
- in_valid  in  1  a result beat is present.
- in_data0, in_data1, in_data2  in  DATA_WIDTH each  filter 0/1/2 results of the beat.
- in_ready  out  1  block accepts beats; a beat transfers on in_valid & in_ready.
- rd_addr{c}_{k}  in  ADDR_W  read address, channel c in 0..2, window row k in 0..2 (9 ports).
- rd_data{c}_{k}  out  DATA_WIDTH  registered read data for the matching address (9 ports).
- wr_count  out  ADDR_W  number of words written in the current frame.
- done  out  1  level; frame complete.
- overflow  out  1  sticky; a beat was presented while in_ready=0.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state IDLE; in_ready=0, done=0, overflow=0, wr_count=0, all rd_data=0.
  - Buffer contents are not cleared.
  - Reset mid-frame aborts the frame in the same way.
- States:
  - IDLE: start -> FILL.
  - FILL: in_ready=1. Each transfer writes in_data{c} to buffer c at the current address, then increments the address, col and wr_count. col wraps at OUT_W-1 to 0 and row increments.
  - The address is held in an incrementing counter; no multiplier.
  - The transfer that writes address OUTPUT_SIZE-1 moves FILL -> DONE. done=1 and in_ready=0 from the next cycle.
  - DONE: done holds 1; start -> FILL with done=0 the next cycle.
- start in any state: next cycle address, row, col and wr_count are 0, overflow=0, state FILL. A beat presented in the same cycle as start is not written and does not set overflow.
- Overflow: in_valid=1 while in_ready=0 (IDLE or DONE) sets overflow sticky. The beat is dropped and memory is unchanged.
- Reads:
  - Latency 1 cycle, available in every state, all 9 ports independent.
  - Address >= OUTPUT_SIZE returns 0.
  - Read and write to the same address in the same cycle returns the old data (read-first).
- Arithmetic: data is stored verbatim, no width change (except under the optional feature). wr_count saturates at OUTPUT_SIZE.

Optional Feature:
- Macro FMAP_RELU_EN.
- Defined: each in_data{c} with MSB=1 (negative) is stored as 0; non-negative values are stored unchanged. Applied on the write path, no added latency.
- Undefined: values are stored verbatim, including negatives.

Decomposition:
- Package fmap_pkg:
  - state encoding (IDLE=2'd0, FILL=2'd1, DONE=2'd2);
  - default ADDR_W;
  - a function computing OUTPUT_SIZE from OUT_W and OUT_H.
- Sub-module fmap_bram_3r1w: one write port and three registered read-first ports with out-of-range zeroing, instantiated once per channel.
- fmap_writer holds the FSM, counters, the optional ReLU and the overflow flag.

Test Plan (OUT_W=4, OUT_H=3 unless noted):
- Reset then start, then 12 contiguous beats with in_data0=k, in_data1=100+k, in_data2=200+k (k=0..11):
  - done=1 on the cycle after beat 11 and wr_count=12;
  - rd_addr0_1=5 returns 5, rd_addr2_2=11 returns 211, each one cycle after the address is applied.
- Beats gapped (in_valid toggling 1,0,1,0) -> identical memory contents; done exactly once, after beat 11.
- After done, one extra beat with in_data0=77 -> overflow=1, address 0 still reads 0. Then start -> overflow=0, done=0, in_ready=1.
- rst=0 after 6 beats -> in_ready=0, wr_count=0, done=0. Then start and 12 beats -> done, address 0 reads the new beat 0.
- Write to address 3 while rd_addr1_0=3 in the same cycle -> rd_data1_0 returns old value, new value on the next read. rd_addr=12 -> 0.
- With FMAP_RELU_EN defined, in_data0=-5 at address 2 -> reads 0. Undefined -> reads -5 (22'h3FFFFB).
